// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Port 0 is instruction fetch, port 1 is load/store; one access in flight at a time.
module mem_port_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t state, state_nxt;
   logic   winner;   // port owning the current transaction
   logic   last;     // port granted most recently
   logic   any_req;
   logic   sel;

   // On a tie the port not granted last wins.
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) sel = ~last;
      else              sel = req1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      case (state)
         IDLE:  if (any_req) state_nxt = ISSUE;
         ISSUE: begin
            gnt0      = ~winner;
            gnt1      = winner;
            state_nxt = ram_we ? IDLE : WAIT;
         end
         WAIT: begin
            rvalid0   = ~winner;
            rvalid1   = winner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ram_we is a one-cycle pulse: set when latching a write, cleared on every other edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         winner    <= 1'b0;
         last      <= 1'b1;
      end else begin
         ram_we <= 1'b0;
         if (state == IDLE && any_req) begin
            winner    <= sel;
            ram_addr  <= sel ? addr1  : addr0;
            ram_wdata <= sel ? wdata1 : wdata0;
            ram_we    <= sel ? we1    : we0;
         end
         if (state == ISSUE) last <= winner;
      end
   end

   assign rdata0 = ram_rdata;
   assign rdata1 = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM attached.
module tb_mem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, rvalid0, gnt1, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Mutual exclusion of strobes, checked every cycle away from the edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         vectors++;
         if ((gnt0 & gnt1) !== 1'b0 || (rvalid0 & rvalid1) !== 1'b0) begin
            miscompares++;
            $display("FAIL mutex: gnt=%b%b rvalid=%b%b want no double strobe", gnt0, gnt1, rvalid0, rvalid1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({gnt0, gnt1, rvalid0, rvalid1, ram_we} !== 5'b0 || ram_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_idle[%0d]: g=%b%b v=%b%b we=%b addr=%h want all 0", i,
                     gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr);
         end
         tick();
      end
   endtask

   task automatic test_read0();
      req0 = 1; we0 = 0; addr0 = 8'd7;
      tick();
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b100 || ram_addr !== 8'd7) begin
         miscompares++;
         $display("FAIL read0_gnt: g=%b%b we=%b addr=%h want g=10 we=0 addr=07", gnt0, gnt1, ram_we, ram_addr);
      end
      req0 = 0;
      tick();
      vectors++;
      if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b1000 || rdata0 !== 16'd35) begin
         miscompares++;
         $display("FAIL read0_rvalid: v=%b%b g=%b%b rdata0=%0d want v=10 rdata0=35", rvalid0, rvalid1, gnt0, gnt1, rdata0);
      end
      tick();
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
         miscompares++;
         $display("FAIL read0_idle: g=%b%b v=%b%b want 0", gnt0, gnt1, rvalid0, rvalid1);
      end
   endtask

   task automatic test_write1();
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 16'hBEEF;
      tick();
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b011 || ram_addr !== 8'h20 || ram_wdata !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL write1_gnt: g=%b%b we=%b addr=%h wdata=%h want g=01 we=1 addr=20 wdata=beef",
                  gnt0, gnt1, ram_we, ram_addr, ram_wdata);
      end
      req1 = 0; we1 = 0;
      tick();
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_we} !== 5'b0) begin
         miscompares++;
         $display("FAIL write1_after: g=%b%b v=%b%b we=%b want 0", gnt0, gnt1, rvalid0, rvalid1, ram_we);
      end
      // Readback through port 0; the arbiter is back in IDLE here.
      req0 = 1; we0 = 0; addr0 = 8'h20;
      tick();
      vectors++;
      if (gnt0 !== 1'b1) begin
         miscompares++;
         $display("FAIL write1_rb_gnt: gnt0=%b want 1", gnt0);
      end
      req0 = 0;
      tick();
      vectors++;
      if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL write1_readback: rvalid0=%b rdata0=%h want 1 beef", rvalid0, rdata0);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [DW-1:0] exp_d;
      logic          p;
      do_reset();
      req0 = 1; we0 = 0; addr0 = 8'd7;
      req1 = 1; we1 = 0; addr1 = 8'd8;
      for (int t = 0; t < 4; t++) begin
         p     = t[0];
         exp_d = p ? 16'h1234 : 16'd35;
         tick();
         vectors++;
         if ({gnt0, gnt1} !== {~p, p} || ram_addr !== (p ? 8'd8 : 8'd7)) begin
            miscompares++;
            $display("FAIL contend_gnt[%0d]: g=%b%b addr=%h want g=%b%b", t, gnt0, gnt1, ram_addr, ~p, p);
         end
         tick();
         vectors++;
         if ({rvalid0, rvalid1} !== {~p, p} || (p ? rdata1 : rdata0) !== exp_d) begin
            miscompares++;
            $display("FAIL contend_rv[%0d]: v=%b%b rdata=%h want v=%b%b rdata=%h", t, rvalid0, rvalid1,
                     p ? rdata1 : rdata0, ~p, p, exp_d);
         end
         tick();
      end
      req0 = 0; req1 = 0;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a;
      req0 = 1; we0 = 0; addr0 = 8'd7;
      for (int t = 0; t < 3; t++) begin
         a = 8'd7 + 8'(t);
         tick();
         vectors++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_addr !== a) begin
            miscompares++;
            $display("FAIL b2b_gnt[%0d]: g=%b%b addr=%h want g=10 addr=%h", t, gnt0, gnt1, ram_addr, a);
         end
         if (t == 2) req0 = 0;
         else        addr0 = a + 8'd1;
         tick();
         vectors++;
         if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== mem[a]) begin
            miscompares++;
            $display("FAIL b2b_rv[%0d]: v=%b%b rdata0=%h want v=10 rdata0=%h", t, rvalid0, rvalid1, rdata0, mem[a]);
         end
         tick();
         vectors++;
         if (gnt0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap[%0d]: gnt0=%b want 0", t, gnt0);
         end
      end
   endtask

   task automatic test_reset_in_issue();
      req0 = 1; we0 = 0; addr0 = 8'd7;
      tick();
      vectors++;
      if (gnt0 !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_issue_gnt: gnt0=%b want 1", gnt0);
      end
      req0  = 0;
      rst_n = 0;
      tick();
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_we} !== 5'b0) begin
         miscompares++;
         $display("FAIL rst_issue_drop: g=%b%b v=%b%b we=%b want 0", gnt0, gnt1, rvalid0, rvalid1, ram_we);
      end
      rst_n = 1;
      tick();
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
         miscompares++;
         $display("FAIL rst_issue_norv: g=%b%b v=%b%b want 0", gnt0, gnt1, rvalid0, rvalid1);
      end
      req0 = 1; addr0 = 8'd7;
      req1 = 1; we1 = 0; addr1 = 8'd8;
      tick();
      vectors++;
      if ({gnt0, gnt1} !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_issue_tie: g=%b%b want 10", gnt0, gnt1);
      end
      req0 = 0; req1 = 0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 3);
      mem[7] = 16'd35;
      mem[8] = 16'h1234;
      mem[9] = 16'h0099;
      rst_n = 0;
      test_reset();
      test_read0();
      test_write1();
      test_contention();
      test_back_to_back();
      test_reset_in_issue();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
